pool_scheduler: RTL

- Sequences a 2x2 stride-2 max-pool pass over a feature map held in an on-chip buffer.
- Latches map dimensions on start and generates the four window read addresses per output.
- Tracks the running maximum from returned data and emits one pooled value per window on a valid/ready stream.
- Sits between the activation buffer (read port) and the downstream writeback/next-layer stage.

---
 rtl/pool_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pool_scheduler.sv
// rtl/pool_scheduler.sv - 2x2 stride-2 max-pool sequencer over a row-major activation buffer
module pool_scheduler #(
    parameter int DATA_W = 8,
    parameter int DIM_W  = 5,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [DIM_W-1:0]  cfg_h,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx
);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;

    localparam logic [31:0] AREA_MAX = 32'(1) << ADDR_W;

    state_t            state;
    logic [DIM_W-1:0]  w_q, h_q, pr, pc;
    logic [1:0]        k;
    logic              cap_valid, cap_first;
    logic [DATA_W-1:0] run_max, cand;
    logic [DIM_W-1:0]  half_w, pc_nxt, pr_nxt;
    logic [ADDR_W-1:0] n_win;
    logic              last_col, last_win, cfg_ok;

    function automatic logic [ADDR_W-1:0] win_addr(input logic [DIM_W-1:0] r,
                                                   input logic [DIM_W-1:0] c,
                                                   input logic [DIM_W-1:0] w,
                                                   input logic [1:0]       kk);
        return ADDR_W'(32'(r) * 32'(w) * 32'd2 + 32'(c) * 32'd2
                       + (kk[1] ? 32'(w) : 32'd0) + 32'(kk[0]));
    endfunction

    always_comb begin
        // cap_first marks the k=0 return, which always reloads the max
        cand     = (cap_first || mem_rd_data > run_max) ? mem_rd_data : run_max;
        half_w   = w_q >> 1;
        last_col = (pc == half_w - 1'b1);
        pc_nxt   = last_col ? '0 : pc + 1'b1;
        pr_nxt   = last_col ? pr + 1'b1 : pr;
        n_win    = ADDR_W'(32'(w_q >> 1) * 32'(h_q >> 1));
        last_win = (out_idx == n_win - 1'b1);
        cfg_ok   = (cfg_w != '0) && !cfg_w[0] && (cfg_h != '0) && !cfg_h[0]
                   && (32'(cfg_w) * 32'(cfg_h) <= AREA_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_idx     <= '0;
            w_q         <= '0;
            h_q         <= '0;
            pr          <= '0;
            pc          <= '0;
            k           <= '0;
            cap_valid   <= 1'b0;
            cap_first   <= 1'b0;
            run_max     <= '0;
        end else begin
            err       <= 1'b0;
            done      <= 1'b0;
            cap_valid <= mem_rd_en;
            cap_first <= mem_rd_en && (k == 2'd0);
            if (cap_valid) begin
                run_max <= cand;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            w_q         <= cfg_w;
                            h_q         <= cfg_h;
                            pr          <= '0;
                            pc          <= '0;
                            out_idx     <= '0;
                            k           <= 2'd0;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= '0;
                            busy        <= 1'b1;
                            state       <= FETCH;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (k == 2'd3) begin
                        mem_rd_en <= 1'b0;
                        state     <= WAIT;
                    end else begin
                        k           <= k + 2'd1;
                        mem_rd_addr <= win_addr(pr, pc, w_q, k + 2'd1);
                    end
                end
                WAIT: begin
                    // k=3 data arrives now, so fold it in directly
                    out_data  <= cand;
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_idx   <= out_idx + 1'b1;
                        pc        <= pc_nxt;
                        pr        <= pr_nxt;
                        if (last_win) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            k           <= 2'd0;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= win_addr(pr_nxt, pc_nxt, w_q, 2'd0);
                            state       <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
